// File: rtl/seg_pattern_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_pattern_decoder: 7-segment pattern -> BCD digit, 2-digit accumulator  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module seg_pattern_decoder #(
  parameter int STABLE_CYCLES = 2
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       clear,
  input  logic [7:0] seg_in,
  input  logic       strobe,
  output logic [3:0] digit_out,
  output logic       valid,
  output logic       error,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] value,
  output logic [3:0] err_count,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    DECODE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [6:0] lat, lat_n;
  logic [3:0] digit_n, tens_n, ones_n, err_count_n;
  logic [6:0] value_n;
  logic       valid_n, error_n;
  logic [4:0] dec;
  logic       unused_dp;

  assign unused_dp = seg_in[7];

  // {legal, digit}; only exact matches on segments a..g are legal
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3f:   decode = {1'b1, 4'd0};
      7'h06:   decode = {1'b1, 4'd1};
      7'h5b:   decode = {1'b1, 4'd2};
      7'h4f:   decode = {1'b1, 4'd3};
      7'h66:   decode = {1'b1, 4'd4};
      7'h6d:   decode = {1'b1, 4'd5};
      7'h7d:   decode = {1'b1, 4'd6};
      7'h07:   decode = {1'b1, 4'd7};
      7'h7f:   decode = {1'b1, 4'd8};
      7'h6f:   decode = {1'b1, 4'd9};
      default: decode = {1'b0, 4'd0};
    endcase
  endfunction

  assign dec  = decode(lat);
  assign busy = (state != IDLE);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    lat_n       = lat;
    valid_n     = 1'b0;
    error_n     = 1'b0;
    digit_n     = digit_out;
    tens_n      = tens;
    ones_n      = ones;
    value_n     = value;
    err_count_n = err_count;

    case (state)
      IDLE: begin
        if (strobe) begin
          lat_n   = seg_in[6:0];
          cnt_n   = 4'd1;
          state_n = (STABLE_CYCLES == 1) ? DECODE : QUAL;
        end
      end
      QUAL: begin
        if (!strobe) begin
          state_n = IDLE;
        end else if (seg_in[6:0] != lat) begin
          lat_n = seg_in[6:0];
          cnt_n = 4'd1;
        end else begin
          cnt_n = cnt + 4'd1;
          if (cnt + 4'd1 == STABLE_LAST) state_n = DECODE;
        end
      end
      DECODE: begin
        if (dec[4]) begin
          valid_n = 1'b1;
          digit_n = dec[3:0];
          tens_n  = ones;
          ones_n  = dec[3:0];
          value_n = {3'b000, ones} * 7'd10 + {3'b000, dec[3:0]};
        end else begin
          error_n = 1'b1;
          if (err_count != 4'd15) err_count_n = err_count + 4'd1;
        end
        state_n = RELEASE;
      end
      RELEASE: begin
        if (!strobe) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // clear overrides accumulator updates but leaves pulses and digit alone
    if (clear) begin
      tens_n      = 4'd0;
      ones_n      = 4'd0;
      value_n     = 7'd0;
      err_count_n = 4'd0;
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat       <= 7'd0;
      digit_out <= 4'd0;
      valid     <= 1'b0;
      error     <= 1'b0;
      tens      <= 4'd0;
      ones      <= 4'd0;
      value     <= 7'd0;
      err_count <= 4'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      lat       <= lat_n;
      digit_out <= digit_n;
      valid     <= valid_n;
      error     <= error_n;
      tens      <= tens_n;
      ones      <= ones_n;
      value     <= value_n;
      err_count <= err_count_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_pattern_decoder.sv
`default_nettype none
// Scoreboard bench for seg_pattern_decoder (STABLE_CYCLES = 2).
module tb_seg_pattern_decoder;

  logic       clk_2 = 1'b0;
  logic       reset, clear, strobe;
  logic [7:0] seg_in;
  logic [3:0] digit_out, tens, ones, err_count;
  logic       valid, error, busy;
  logic [6:0] value;

  seg_pattern_decoder #(.STABLE_CYCLES(2)) dut (
    .clk_2(clk_2), .reset(reset), .clear(clear), .seg_in(seg_in), .strobe(strobe),
    .digit_out(digit_out), .valid(valid), .error(error), .tens(tens), .ones(ones),
    .value(value), .err_count(err_count), .busy(busy)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    bit is_err;
    int digit, tens, ones, value, errc, cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0, fails = 0, cyc = 0;
  int   m_digit = 0, m_tens = 0, m_ones = 0, m_errc = 0;
  bit   prev_pulse = 0;

  always @(posedge clk_2) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ref_digit(input logic [6:0] p);
    case (p)
      7'h3f: return 0;  7'h06: return 1;  7'h5b: return 2;  7'h4f: return 3;
      7'h66: return 4;  7'h6d: return 5;  7'h7d: return 6;  7'h07: return 7;
      7'h7f: return 8;  7'h6f: return 9;
      default: return -1;
    endcase
  endfunction

  task automatic push_exp(input logic [6:0] p, input bit clr, input int exp_cyc);
    exp_t e;
    int   d;
    d = ref_digit(p);
    e.is_err = (d < 0);
    if (d >= 0) begin
      m_digit = d;
      m_tens  = m_ones;
      m_ones  = d;
    end else if (m_errc < 15) begin
      m_errc++;
    end
    if (clr) begin
      m_tens = 0; m_ones = 0; m_errc = 0;
    end
    e.digit = m_digit; e.tens = m_tens; e.ones = m_ones;
    e.value = m_tens * 10 + m_ones; e.errc = m_errc; e.cyc = exp_cyc;
    sb.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_digit"}, digit_out, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_tens"}, tens, 0);
    check({tag, "_ones"}, ones, 0);
    check({tag, "_value"}, value, 0);
    check({tag, "_errc"}, err_count, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // One entry: strobe high for 'hold' samples, pattern switches to pat2 for the second sample.
  task automatic entry(input logic [7:0] pat, input logic [7:0] pat2, input int hold,
                       input bit clr_dec);
    @(negedge clk_2);
    push_exp(pat2[6:0], clr_dec, cyc + 3 + ((pat2[6:0] != pat[6:0]) ? 1 : 0));
    seg_in = pat;
    strobe = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_2);
      if (i == 0) begin
        check("busy_rise", busy, 1);
        seg_in = pat2;
      end
      clear = clr_dec && (i == 1);
    end
    strobe = 1'b0;
    clear  = 1'b0;
    @(negedge clk_2);
    check("busy_fall", busy, 0);
    @(negedge clk_2);
  endtask

  // Output monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk_2) begin
    if (valid || error) begin
      exp_t e;
      check("pulse_excl", int'(valid && error), 0);
      check("pulse_b2b", int'(prev_pulse), 0);
      check("sb_nonempty", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pulse_err", int'(error), int'(e.is_err));
        check("pulse_cycle", cyc, e.cyc);
        check("digit_out", digit_out, e.digit);
        check("tens", tens, e.tens);
        check("ones", ones, e.ones);
        check("value", value, e.value);
        check("err_count", err_count, e.errc);
      end
    end
    prev_pulse = valid || error;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; strobe = 1'b0; seg_in = 8'h00;
    repeat (3) @(negedge clk_2);
    check_zero("rst");
    reset = 1'b0;
    @(negedge clk_2);

    entry(8'h06, 8'h06, 4, 1'b0);
    entry(8'h5b, 8'h5b, 4, 1'b0);
    check("t1_tens", tens, 1);
    check("t1_ones", ones, 2);
    check("t1_value", value, 12);
    check("t1_digit", digit_out, 2);

    repeat (16) entry(8'h49, 8'h49, 4, 1'b0);
    check("t2_errc_sat", err_count, 15);
    check("t2_value", value, 12);
    entry(8'h3f, 8'h3f, 4, 1'b0);
    check("t2_digit", digit_out, 0);

    @(negedge clk_2);
    seg_in = 8'h06;
    strobe = 1'b1;
    @(negedge clk_2);
    check("short_busy_hi", busy, 1);
    strobe = 1'b0;
    @(negedge clk_2);
    check("short_busy_lo", busy, 0);
    repeat (3) @(negedge clk_2);
    check("short_idle", busy, 0);

    entry(8'h7f, 8'h6f, 20, 1'b0);
    check("chg_digit", digit_out, 9);

    entry(8'he6, 8'he6, 4, 1'b0);
    entry(8'h07, 8'h07, 4, 1'b0);
    check("acc47", value, 47);
    entry(8'h6d, 8'h6d, 4, 1'b1);
    check("clr_digit", digit_out, 5);
    check("clr_value", value, 0);
    check("clr_errc", err_count, 0);

    @(negedge clk_2);
    push_exp(7'h4f, 1'b0, cyc + 3);
    seg_in = 8'h4f;
    strobe = 1'b1;
    repeat (5) @(negedge clk_2);
    check("rel_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk_2);
    check_zero("rst_rel");
    @(negedge clk_2);
    m_digit = 0; m_tens = 0; m_ones = 0; m_errc = 0;
    push_exp(7'h4f, 1'b0, cyc + 3);
    reset = 1'b0;
    repeat (6) @(negedge clk_2);
    strobe = 1'b0;
    repeat (3) @(negedge clk_2);
    check("post_rst_value", value, 3);

    repeat (5) @(negedge clk_2);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
